prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, number of program memory entries (power of two).
REQ-002 Parameter TIMEOUT, default 16, maximum WAIT cycles allowed for Done per instruction.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 LoadEn  input  1  program memory write strobe.
REQ-006 LoadAddr  input  log2(DEPTH)  program memory write address.
REQ-007 LoadFunc  input  10  function word written at LoadAddr.
REQ-008 LoadData  input  8  data byte written at LoadAddr.
REQ-009 ProgLen  input  log2(DEPTH)+1  number of instructions to run, 0..DEPTH.
REQ-010 Start  input  1  run request, sampled only in IDLE.
REQ-011 Done  input  1  instruction-complete from the processor.
REQ-012 Func  output  10  function word driven to the processor.
REQ-013 Data  output  8  data byte driven to the processor.
REQ-014 w  output  1  one-cycle instruction-issue strobe to the processor.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Finished  output  1  one-cycle pulse on successful program completion.
REQ-017 Error  output  1  sticky timeout flag.
REQ-018 PC  output  log2(DEPTH)  index of the current or last issued instruction.

Function
REQ-019 States: IDLE, ISSUE, WAIT, FINISH, ERROR.
REQ-020 LoadEn SHALL write {LoadFunc, LoadData} to memory[LoadAddr] only in IDLE or ERROR; it SHALL be ignored when Busy is high in ISSUE, WAIT or FINISH.
REQ-021 In IDLE, Start=1 with ProgLen=0 SHALL go to FINISH and SHALL NOT issue any instruction.
REQ-022 In IDLE, Start=1 with ProgLen>0 SHALL latch ProgLen, set PC=0 and go to ISSUE.
REQ-023 ISSUE SHALL last exactly one cycle, with w=1 and Func/Data = memory[PC]; it SHALL then go to WAIT.
REQ-024 Func and Data SHALL remain stable from the ISSUE cycle until the cycle after Done is sampled, because the processor samples Data two cycles after issue.
REQ-025 w SHALL be 0 in every state except ISSUE.
REQ-026 Done SHALL be ignored in the ISSUE cycle, in IDLE, in FINISH and in ERROR.
REQ-027 In WAIT, Done=1 with PC = latched length-1 SHALL go to FINISH.
REQ-028 In WAIT, Done=1 otherwise SHALL increment PC and go to ISSUE on the next cycle.
REQ-029 The WAIT cycle counter SHALL reset on entry to WAIT; when TIMEOUT cycles elapse without Done, the block SHALL go to ERROR with Error=1.
REQ-030 FINISH SHALL last one cycle with Finished=1 and SHALL then return to IDLE.
REQ-031 ERROR SHALL hold Error=1 and Busy=1 until Reset or Start; Start SHALL clear Error and return to IDLE without issuing an instruction.
REQ-032 Start in any state other than IDLE or ERROR SHALL be ignored.
REQ-033 PC SHALL NOT wrap: a latched length of DEPTH ends after entry DEPTH-1.

Reset
REQ-034 Reset SHALL force IDLE, PC=0, Func=0, Data=0, w=0, Busy=0, Finished=0, Error=0 and clear the timeout counter at the next edge, including mid-operation.
REQ-035 Program memory contents SHALL NOT be cleared by Reset.

Structure
REQ-036 State encoding, the Func width (10) and the Data width (8) SHALL live in a shared package used by the processor and this block.
REQ-037 Program storage SHALL be one sub-module, prog_mem: a synchronous write, combinational read, DEPTH x 18 array.

Verification
REQ-038 Load 3 entries (0x0C8/0x55, 0x101/0x00, 0x10A/0x00), ProgLen=3, Start, Done returned 2 cycles after each w -> exactly 3 w pulses, Func matching each entry, Finished once, PC=2.
REQ-039 ProgLen=0, Start -> Finished pulse on the cycle after Start, w never asserted.
REQ-040 ProgLen=2, Done never returned -> Error=1 exactly TIMEOUT cycles after entering WAIT, w pulsed once; a following Start -> IDLE with Error=0.
REQ-041 Done held high during the ISSUE cycle, then low for 3 cycles, then high -> advance occurs only on the WAIT Done.
REQ-042 Reset asserted in WAIT of instruction 1 -> next cycle IDLE, w=0, Func=0; a re-Start runs from PC=0.
REQ-043 LoadEn to entry 0 while Busy -> memory unchanged; ProgLen=16 -> 16 issues with no PC wrap.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// Shared types and widths for the program sequencer and the processor it feeds.
// Holds the sequencer state encoding, the function/data widths and the packed
// program-memory word layout.
package prog_sequencer_pkg;

  localparam int unsigned FUNC_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = FUNC_W + DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FINISH = 3'd3,
    ST_ERROR  = 3'd4
  } seq_state_e;

  // One program entry: function word in the upper bits, data byte below.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] data;
  } prog_word_t;

endpackage

// File: rtl/prog_sequencer_if.sv
// Bundle of the sequencer's load, control and processor-facing signals.
// slave  : seen by prog_sequencer (load/control/Done in, Func/Data/w/status out)
// master : seen by the host/processor side driving the sequencer
interface prog_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  import prog_sequencer_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic              LoadEn;
  logic [AW-1:0]     LoadAddr;
  logic [FUNC_W-1:0] LoadFunc;
  logic [DATA_W-1:0] LoadData;
  logic [AW:0]       ProgLen;
  logic              Start;
  logic              Done;
  logic [FUNC_W-1:0] Func;
  logic [DATA_W-1:0] Data;
  logic              w;
  logic              Busy;
  logic              Finished;
  logic              Error;
  logic [AW-1:0]     PC;

  modport slave (
    input  LoadEn, LoadAddr, LoadFunc, LoadData, ProgLen, Start, Done,
    output Func, Data, w, Busy, Finished, Error, PC
  );

  modport master (
    output LoadEn, LoadAddr, LoadFunc, LoadData, ProgLen, Start, Done,
    input  Func, Data, w, Busy, Finished, Error, PC
  );

endinterface

// File: rtl/prog_sequencer_prog_mem.sv
// prog_mem: DEPTH x 18 program store, synchronous write, combinational read.
// Ports: clk, we/waddr/wdata (write side), raddr/rdata_c (async read side).
// Contents are deliberately not reset so a program survives a sequencer reset.
module prog_mem
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  prog_word_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output prog_word_t               rdata_c
);

  prog_word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: steps through a loaded program, issuing one {Func, Data}
// entry per instruction with a one-cycle w strobe and waiting for Done.
// Ports: Clock, Reset (sync, active-high), bus (prog_sequencer_if.slave):
//   load port LoadEn/LoadAddr/LoadFunc/LoadData, control ProgLen/Start,
//   processor handshake Done in / Func, Data, w out, status Busy/Finished/
//   Error/PC out. All outputs are registered.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 Clock,
  input logic                 Reset,
  prog_sequencer_if.slave     bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [LW-1:0]     len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              w_q, w_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              error_q, error_d;

  logic              mem_we_c;
  prog_word_t        mem_wdata_c;
  prog_word_t        mem_rdata_c;

  // Loads are only accepted while no program is in flight.
  assign mem_we_c    = bus.LoadEn && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign mem_wdata_c = '{func: bus.LoadFunc, data: bus.LoadData};

  // Read address follows the next PC so the issued word is registered
  // together with the transition into ISSUE.
  prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
    .clk     (Clock),
    .we      (mem_we_c),
    .waddr   (bus.LoadAddr),
    .wdata   (mem_wdata_c),
    .raddr   (pc_d),
    .rdata_c (mem_rdata_c)
  );

  // Next-state, PC, length and timeout counter; outputs derive from state_d.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          if (bus.ProgLen == '0) begin
            state_d = ST_FINISH;
          end else begin
            // Clamp so the PC can never run past the last entry.
            len_d   = (bus.ProgLen > LW'(DEPTH)) ? LW'(DEPTH) : bus.ProgLen;
            pc_d    = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.Done) begin
          if (LW'(pc_q) == (len_q - LW'(1))) begin
            state_d = ST_FINISH;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_ISSUE;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (bus.Start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    w_d        = (state_d == ST_ISSUE);
    busy_d     = (state_d != ST_IDLE);
    finished_d = (state_d == ST_FINISH);
    error_d    = (state_d == ST_ERROR);

    // Func/Data hold the last issued entry until the next issue.
    func_d = func_q;
    data_d = data_q;
    if (state_d == ST_ISSUE) begin
      func_d = mem_rdata_c.func;
      data_d = mem_rdata_c.data;
    end
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      func_q     <= '0;
      data_q     <= '0;
      w_q        <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      func_q     <= func_d;
      data_q     <= data_d;
      w_q        <= w_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      error_q    <= error_d;
    end
  end

  assign bus.Func     = func_q;
  assign bus.Data     = data_q;
  assign bus.w        = w_q;
  assign bus.Busy     = busy_q;
  assign bus.Finished = finished_q;
  assign bus.Error    = error_q;
  assign bus.PC       = pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer. Expected issues are queued from a
// bench-side copy of the program when a run is started and popped as w pulses
// appear; a small responder returns Done a fixed latency after each w.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;

  typedef struct {
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] data;
    logic [AW-1:0]     pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_sequencer_if #(.DEPTH(DEPTH)) ifc ();

  prog_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t              exp_q[$];
  logic [FUNC_W-1:0] mem_func [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  int done_lat   = 0;
  bit done_force = 1'b0;
  int done_cnt   = 0;
  int w_count    = 0;
  int fin_count  = 0;
  logic [FUNC_W-1:0] hold_func = '0;
  logic [DATA_W-1:0] hold_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program-memory write through the load port; bench copy updated alongside.
  task automatic load(input int addr, input logic [FUNC_W-1:0] f, input logic [DATA_W-1:0] d);
    ifc.LoadEn   = 1'b1;
    ifc.LoadAddr = AW'(addr);
    ifc.LoadFunc = f;
    ifc.LoadData = d;
    tick();
    ifc.LoadEn   = 1'b0;
    mem_func[addr] = f;
    mem_data[addr] = d;
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.func = mem_func[idx];
    e.data = mem_data[idx];
    e.pc   = AW'(idx);
    exp_q.push_back(e);
  endtask

  task automatic wait_finish(input string tag);
    int i;
    i = 0;
    while (!ifc.Finished && i < 500) begin
      tick();
      i++;
    end
    ifc.LoadEn = 1'b0;
    chk({tag, "_finish_seen"}, 32'(ifc.Finished), 1);
  endtask

  task automatic start_prog(input int len);
    ifc.ProgLen = LW'(len);
    ifc.Start   = 1'b1;
    tick();
    ifc.Start   = 1'b0;
  endtask

  task automatic run_prog(input int len, input int lat, input string tag);
    done_lat = lat;
    for (int i = 0; i < len; i++) push_exp(i);
    start_prog(len);
    wait_finish(tag);
  endtask

  // Issue monitor, scoreboard pop and Done responder.
  always @(negedge clk) begin
    bit pulse;
    exp_t e;
    pulse = 1'b0;
    if (rst) begin
      done_cnt = 0;
    end else if (done_cnt > 0) begin
      chk("func_hold", 32'(ifc.Func), 32'(hold_func));
      chk("data_hold", 32'(ifc.Data), 32'(hold_data));
      done_cnt--;
      pulse = (done_cnt == 0);
    end
    ifc.Done = done_force | pulse;
    if (ifc.w) begin
      w_count++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_func", 32'(ifc.Func), 32'(e.func));
        chk("issue_data", 32'(ifc.Data), 32'(e.data));
        chk("issue_pc",   32'(ifc.PC),   32'(e.pc));
      end
      hold_func = ifc.Func;
      hold_data = ifc.Data;
      done_cnt  = done_lat;
    end
    if (ifc.Finished) fin_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int f0;
    int i;

    rst          = 1'b1;
    ifc.LoadEn   = 1'b0;
    ifc.LoadAddr = '0;
    ifc.LoadFunc = '0;
    ifc.LoadData = '0;
    ifc.ProgLen  = '0;
    ifc.Start    = 1'b0;
    repeat (3) tick();

    chk("rst_busy",     32'(ifc.Busy),     0);
    chk("rst_w",        32'(ifc.w),        0);
    chk("rst_func",     32'(ifc.Func),     0);
    chk("rst_data",     32'(ifc.Data),     0);
    chk("rst_pc",       32'(ifc.PC),       0);
    chk("rst_finished", 32'(ifc.Finished), 0);
    chk("rst_error",    32'(ifc.Error),    0);
    rst = 1'b0;
    tick();

    // Three-entry program, Done two cycles after each w.
    load(0, 10'h0C8, 8'h55);
    load(1, 10'h101, 8'h00);
    load(2, 10'h10A, 8'h00);
    w0 = w_count; f0 = fin_count;
    run_prog(3, 2, "t1");
    chk("t1_pc", 32'(ifc.PC), 2);
    tick();
    chk("t1_fin_pulse", 32'(ifc.Finished), 0);
    chk("t1_idle",      32'(ifc.Busy),     0);
    chk("t1_w_count",   w_count - w0,      3);
    chk("t1_fin_count", fin_count - f0,    1);
    chk("t1_sb_empty",  exp_q.size(),      0);

    // Empty program: Finished right after Start, nothing issued.
    w0 = w_count;
    start_prog(0);
    chk("t2_finished", 32'(ifc.Finished), 1);
    chk("t2_busy",     32'(ifc.Busy),     1);
    chk("t2_w",        32'(ifc.w),        0);
    tick();
    chk("t2_fin_once", 32'(ifc.Finished), 0);
    chk("t2_idle",     32'(ifc.Busy),     0);
    chk("t2_no_issue", w_count - w0,      0);

    // Done never returned: timeout into ERROR, cleared by Start.
    w0 = w_count;
    done_lat = 0;
    push_exp(0);
    start_prog(2);
    chk("t3_issue_w", 32'(ifc.w), 1);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("t3_no_err_early", 32'(ifc.Error), 0);
    tick();
    chk("t3_error",     32'(ifc.Error), 1);
    chk("t3_err_busy",  32'(ifc.Busy),  1);
    repeat (3) tick();
    chk("t3_err_sticky", 32'(ifc.Error), 1);
    chk("t3_w_once",     w_count - w0,   1);
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    chk("t3_err_clear", 32'(ifc.Error), 0);
    chk("t3_idle",      32'(ifc.Busy),  0);
    tick();
    chk("t3_no_reissue", w_count - w0, 1);
    chk("t3_sb_empty",   exp_q.size(), 0);

    // Done during ISSUE is ignored; only the WAIT Done advances. Start in WAIT ignored.
    done_lat = 0;
    push_exp(0);
    push_exp(1);
    start_prog(2);
    done_force = 1'b1;
    chk("t4_issue_w", 32'(ifc.w), 1);
    tick();
    done_force = 1'b0;
    chk("t4_wait_pc", 32'(ifc.PC), 0);
    chk("t4_wait_w",  32'(ifc.w),  0);
    ifc.Start = 1'b1;
    tick();
    ifc.Start = 1'b0;
    chk("t4_start_ign_pc", 32'(ifc.PC), 0);
    tick();
    tick();
    chk("t4_still_wait_w",  32'(ifc.w),    0);
    chk("t4_still_busy",    32'(ifc.Busy), 1);
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    done_lat = 2;
    chk("t4_adv_w",  32'(ifc.w),  1);
    chk("t4_adv_pc", 32'(ifc.PC), 1);
    wait_finish("t4");
    tick();
    chk("t4_sb_empty", exp_q.size(), 0);

    // Reset in WAIT of instruction 1, then a clean rerun from PC 0.
    done_lat = 2;
    push_exp(0);
    push_exp(1);
    start_prog(3);
    i = 0;
    while (!(ifc.w && ifc.PC == AW'(1)) && i < 50) begin
      tick();
      i++;
    end
    chk("t5_reach_pc1", 32'(ifc.w && ifc.PC == AW'(1)), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy",     32'(ifc.Busy),     0);
    chk("t5_w",        32'(ifc.w),        0);
    chk("t5_func",     32'(ifc.Func),     0);
    chk("t5_data",     32'(ifc.Data),     0);
    chk("t5_pc",       32'(ifc.PC),       0);
    chk("t5_error",    32'(ifc.Error),    0);
    chk("t5_sb_empty", exp_q.size(),      0);
    repeat (3) tick();
    w0 = w_count;
    run_prog(3, 2, "t5r");
    chk("t5r_pc", 32'(ifc.PC), 2);
    tick();
    chk("t5r_w_count",  w_count - w0, 3);
    chk("t5r_sb_empty", exp_q.size(), 0);

    // Full-depth program with a load to entry 0 attempted while busy.
    for (int k = 0; k < DEPTH; k++) begin
      load(k, FUNC_W'(10'h200 + 10'(k * 7)), DATA_W'(8'hA0 + 8'(k)));
    end
    w0 = w_count; f0 = fin_count;
    done_lat = 2;
    for (int k = 0; k < DEPTH; k++) push_exp(k);
    start_prog(DEPTH);
    ifc.LoadEn   = 1'b1;
    ifc.LoadAddr = '0;
    ifc.LoadFunc = 10'h3FF;
    ifc.LoadData = 8'hEE;
    wait_finish("t6");
    chk("t6_pc", 32'(ifc.PC), DEPTH - 1);
    tick();
    chk("t6_w_count",   w_count - w0,   DEPTH);
    chk("t6_fin_count", fin_count - f0, 1);
    chk("t6_sb_empty",  exp_q.size(),   0);
    run_prog(1, 2, "t6b");
    tick();
    chk("t6b_pc",       32'(ifc.PC),  0);
    chk("t6b_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
